smf: RTL and testbench

SMF -- requirements
Module: smf

---
 rtl/smf_pkg.sv | 20 ++
 rtl/smf_median9.sv | 34 +++
 rtl/smf.sv | 160 ++++++++++++++++
 tb/tb_smf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/smf_pkg.sv
// rtl/smf_pkg.sv - shared FSM encoding and 3x3 window geometry for the smf median filter
package smf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMP,
    WRITE,
    COPY,
    DONE
  } smfState_t;

  localparam int WIN_SIZE   = 9;
  localparam int WIN_CENTRE = 4;

  // Row-major 3x3 neighbourhood, relative to the centre pixel
  localparam int WIN_ROW_OFS [WIN_SIZE] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int WIN_COL_OFS [WIN_SIZE] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/smf_median9.sv
// rtl/smf_median9.sv - combinational min / max / median of a 3x3 window
module smf_median9
  import smf_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] window [WIN_SIZE],
  output logic [DATA_WIDTH-1:0] minVal,
  output logic [DATA_WIDTH-1:0] maxVal,
  output logic [DATA_WIDTH-1:0] medVal
);

  logic [DATA_WIDTH-1:0] s [WIN_SIZE];
  logic [DATA_WIDTH-1:0] tmp;

  // Odd-even transposition network: WIN_SIZE alternating compare-exchange stages
  always_comb begin
    tmp = '0;
    for (int i = 0; i < WIN_SIZE; i++) s[i] = window[i];
    for (int p = 0; p < WIN_SIZE; p++) begin
      for (int i = 0; i < WIN_SIZE - 1; i++) begin
        if (((i % 2) == (p % 2)) && (s[i] > s[i+1])) begin
          tmp    = s[i];
          s[i]   = s[i+1];
          s[i+1] = tmp;
        end
      end
    end
    minVal = s[0];
    maxVal = s[WIN_SIZE-1];
    medVal = s[WIN_CENTRE];
  end

endmodule

// File: rtl/smf.sv
// rtl/smf.sv - 3x3 plain / switching median image filter over a raster source and destination memory
module smf
  import smf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  filterEn,
  input  logic                  mode,
  input  logic [DIM_WIDTH-1:0]  M,
  input  logic [DIM_WIDTH-1:0]  N,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [ADDR_WIDTH-1:0] addrIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  wrOut,
  output logic                  busy,
  output logic                  filterF,
  output logic [15:0]           noiseCnt
);

  smfState_t             state, nextState;
  logic [DIM_WIDTH-1:0]  mR, nR, row, col, nextRow, nextCol;
  logic                  modeR, borderPix, lastCol, lastPix;
  logic [ADDR_WIDTH-1:0] pixAddr, winAddr;
  logic [3:0]            loadIdx;
  logic [DATA_WIDTH-1:0] win [WIN_SIZE];
  logic [DATA_WIDTH-1:0] netMin, netMax, netMed, minR, maxR, medR, centre, outPix;

  function automatic logic interiorAt(input logic [DIM_WIDTH-1:0] r, input logic [DIM_WIDTH-1:0] c);
    return (mR >= DIM_WIDTH'(3)) && (nR >= DIM_WIDTH'(3)) && (r != '0) && (c != '0) &&
           (r != mR - DIM_WIDTH'(1)) && (c != nR - DIM_WIDTH'(1));
  endfunction

  assign centre  = win[WIN_CENTRE];
  assign lastCol = (col == nR - DIM_WIDTH'(1));
  assign lastPix = lastCol && (row == mR - DIM_WIDTH'(1));
  assign nextCol = lastCol ? '0 : col + DIM_WIDTH'(1);
  assign nextRow = lastCol ? row + DIM_WIDTH'(1) : row;

  // Modular address arithmetic matches the r*N+c truncation rule
  assign winAddr = pixAddr + ADDR_WIDTH'(WIN_ROW_OFS[loadIdx]) * ADDR_WIDTH'(nR)
                           + ADDR_WIDTH'(WIN_COL_OFS[loadIdx]);

  assign outPix = (borderPix || (modeR && (centre != minR) && (centre != maxR))) ? centre : medR;

  smf_median9 #(.DATA_WIDTH(DATA_WIDTH)) uMedian (
    .window (win),
    .minVal (netMin),
    .maxVal (netMax),
    .medVal (netMed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    addrIn    = '0;
    addrOut   = '0;
    dataOut   = '0;
    wrOut     = 1'b0;
    busy      = 1'b0;
    filterF   = 1'b0;
    case (state)
      IDLE: begin
        if (filterEn) nextState = ((M == '0) || (N == '0)) ? DONE : COPY;
      end
      LOAD: begin
        busy   = 1'b1;
        addrIn = winAddr;
        if (loadIdx == 4'(WIN_SIZE - 1)) nextState = COMP;
      end
      COMP: begin
        busy      = 1'b1;
        nextState = WRITE;
      end
      COPY: begin
        busy      = 1'b1;
        addrIn    = pixAddr;
        nextState = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wrOut   = 1'b1;
        addrOut = pixAddr;
        dataOut = outPix;
        if (lastPix)                         nextState = DONE;
        else if (interiorAt(nextRow, nextCol)) nextState = LOAD;
        else                                 nextState = COPY;
      end
      DONE: begin
        filterF = 1'b1;
        if (!filterEn) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mR        <= '0;
      nR        <= '0;
      modeR     <= 1'b0;
      row       <= '0;
      col       <= '0;
      pixAddr   <= '0;
      loadIdx   <= '0;
      borderPix <= 1'b0;
      minR      <= '0;
      maxR      <= '0;
      medR      <= '0;
      noiseCnt  <= '0;
      for (int i = 0; i < WIN_SIZE; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (filterEn) begin
            mR       <= M;
            nR       <= N;
            modeR    <= mode;
            row      <= '0;
            col      <= '0;
            pixAddr  <= '0;
            loadIdx  <= '0;
            noiseCnt <= '0;
          end
        end
        LOAD: begin
          win[loadIdx] <= dataIn;
          loadIdx      <= loadIdx + 4'd1;
        end
        COPY: begin
          win[WIN_CENTRE] <= dataIn;
          borderPix       <= 1'b1;
        end
        COMP: begin
          minR      <= netMin;
          maxR      <= netMax;
          medR      <= netMed;
          borderPix <= 1'b0;
        end
        WRITE: begin
          if ((outPix != centre) && (noiseCnt != 16'hFFFF)) noiseCnt <= noiseCnt + 16'd1;
          row     <= nextRow;
          col     <= nextCol;
          pixAddr <= pixAddr + ADDR_WIDTH'(1);
          loadIdx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smf.sv
// tb/tb_smf.sv - self-checking bench for smf against a behavioural image-filter model
module tb_smf;

  logic        clk = 1'b0;
  logic        rst, filterEn, mode;
  logic [15:0] M, N;
  logic [7:0]  dataIn, dataOut, addrIn, addrOut;
  logic        wrOut, busy, filterF;
  logic [15:0] noiseCnt;

  logic [7:0] srcMem [256];
  logic [7:0] dstMem [256];
  logic [7:0] expMem [256];

  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int busyCnt = 0;
  int orderErr = 0;
  int expNoise, expBusy;

  smf dut (
    .clk      (clk),
    .rst      (rst),
    .filterEn (filterEn),
    .mode     (mode),
    .M        (M),
    .N        (N),
    .dataIn   (dataIn),
    .addrIn   (addrIn),
    .dataOut  (dataOut),
    .addrOut  (addrOut),
    .wrOut    (wrOut),
    .busy     (busy),
    .filterF  (filterF),
    .noiseCnt (noiseCnt)
  );

  always #5 clk = ~clk;

  assign dataIn = srcMem[addrIn];

  always @(negedge clk) begin
    if (busy) busyCnt++;
    if (wrOut) begin
      if (addrOut !== 8'(wrCount)) orderErr++;
      dstMem[addrOut] = dataOut;
      wrCount++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: border copy, 5th-smallest median, switching rule applied to the centre
  task automatic buildModel(input int m, input int n, input bit md);
    logic [7:0] w [9];
    logic [7:0] ctr, mn, mx, med, outv;
    int interior, border, lt, le, a;
    interior = 0;
    border   = 0;
    expNoise = 0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        a   = (r * n + c) % 256;
        ctr = srcMem[a];
        if (r == 0 || c == 0 || r == m - 1 || c == n - 1) begin
          outv = ctr;
          border++;
        end else begin
          for (int k = 0; k < 9; k++) w[k] = srcMem[((r + k / 3 - 1) * n + c + k % 3 - 1) % 256];
          mn  = w[0];
          mx  = w[0];
          med = w[0];
          for (int k = 0; k < 9; k++) begin
            if (w[k] < mn) mn = w[k];
            if (w[k] > mx) mx = w[k];
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
              if (w[j] < w[k])  lt++;
              if (w[j] <= w[k]) le++;
            end
            if (lt <= 4 && le >= 5) med = w[k];
          end
          outv = (!md || ctr == mn || ctr == mx) ? med : ctr;
          interior++;
        end
        expMem[a] = outv;
        if (outv != ctr && expNoise < 65535) expNoise++;
      end
    end
    expBusy = 11 * interior + 2 * border;
  endtask

  task automatic runFilter(input int m, input int n, input bit md, input bit wiggle, input string name);
    int cyc;
    buildModel(m, n, md);
    for (int i = 0; i < 256; i++) dstMem[i] = 8'hxx;
    wrCount  = 0;
    busyCnt  = 0;
    orderErr = 0;
    M        = 16'(m);
    N        = 16'(n);
    mode     = md;
    filterEn = 1'b1;
    cyc      = 0;
    @(negedge clk);
    while (!filterF && cyc < 4000) begin
      if (wiggle) begin
        M    = 16'($urandom_range(0, 20));
        N    = 16'($urandom_range(0, 20));
        mode = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check({name, " done"}, filterF, 1);
    check({name, " busyNow"}, busy, 0);
    check({name, " writes"}, wrCount, m * n);
    check({name, " busyCycles"}, busyCnt, expBusy);
    check({name, " noiseCnt"}, noiseCnt, expNoise);
    check({name, " rasterOrder"}, orderErr, 0);
    for (int a = 0; a < m * n; a++) check($sformatf("%s dst[%0d]", name, a), dstMem[a], expMem[a]);
  endtask

  task automatic endRun(input string name);
    filterEn = 1'b0;
    @(negedge clk);
    check({name, " filterF cleared"}, filterF, 0);
  endtask

  task automatic checkOutputsZero(input string name);
    check({name, " addrIn"}, addrIn, 0);
    check({name, " addrOut"}, addrOut, 0);
    check({name, " dataOut"}, dataOut, 0);
    check({name, " wrOut"}, wrOut, 0);
    check({name, " busy"}, busy, 0);
    check({name, " filterF"}, filterF, 0);
    check({name, " noiseCnt"}, noiseCnt, 0);
  endtask

  initial begin
    int m, n;
    rst      = 1'b1;
    filterEn = 1'b0;
    mode     = 1'b0;
    M        = '0;
    N        = '0;
    for (int i = 0; i < 256; i++) srcMem[i] = 8'(i);
    repeat (3) @(negedge clk);
    checkOutputsZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ramp: median of a linear ramp reproduces the ramp
    runFilter(15, 15, 1'b0, 1'b1, "ramp");
    check("ramp busy total", busyCnt, 1971);
    endRun("ramp");

    // Single impulse in the switching mode
    srcMem[80] = 8'd255;
    runFilter(15, 15, 1'b1, 1'b0, "imp1");
    check("imp1 dst[80] const", dstMem[80], 81);
    check("imp1 noise const", noiseCnt, 1);
    endRun("imp1");

    // Same impulse, plain median
    runFilter(15, 15, 1'b0, 1'b0, "imp0");
    check("imp0 dst[80] const", dstMem[80], 81);
    check("imp0 dst[79] const", dstMem[79], 79);
    endRun("imp0");

    // Too few rows: everything is border; then hold filterEn after completion
    for (int i = 0; i < 256; i++) srcMem[i] = 8'(i);
    runFilter(2, 15, 1'b0, 1'b0, "deg");
    check("deg dst[29] const", dstMem[29], 29);
    repeat (20) @(negedge clk);
    check("hold filterF", filterF, 1);
    check("hold busy", busy, 0);
    check("hold writes", wrCount, 30);
    endRun("hold");
    @(negedge clk);
    check("hold idle busy", busy, 0);

    // Zero dimension: straight to done
    wrCount  = 0;
    M        = 16'd0;
    N        = 16'd15;
    filterEn = 1'b1;
    @(negedge clk);
    check("zeroM filterF", filterF, 1);
    check("zeroM busy", busy, 0);
    check("zeroM writes", wrCount, 0);
    endRun("zeroM");

    // Reset in the middle of a run
    M        = 16'd15;
    N        = 16'd15;
    mode     = 1'b0;
    filterEn = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutputsZero("midReset");
    filterEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midReset abandoned", busy, 0);
    runFilter(15, 15, 1'b0, 1'b0, "rerun");
    check("rerun busy total", busyCnt, 1971);
    endRun("rerun");

    // Random images with sprinkled impulses
    for (int t = 0; t < 4; t++) begin
      m = $urandom_range(1, 16);
      n = $urandom_range(1, 16);
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 9) == 0) srcMem[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        else                           srcMem[i] = 8'($urandom_range(40, 200));
      end
      runFilter(m, n, 1'($urandom), 1'b1, $sformatf("rand%0d", t));
      endRun($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
